fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage that carries out the pipeline control decisions made by the branch hazard FSM. It drives the instruction-memory request/ready interface and owns the PC register. It loads IR1, or injects a NOP when told to, and applies PC increment or branch redirect as directed by IR1Sel, ALUPC1 and PCSel. Sits between instruction memory and the decode stage (IR1).

Parameters:
ADDR_W, 8, PC / memory address width
DATA_W, 8, instruction width
NOP_INSN, 8'h0A, encoding injected into IR1 when no valid instruction is delivered
WAIT_LIMIT, 15, max cycles a request may wait for mem_ready before fetch_err sets

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
IR1Sel  in  1  1 = latch fetched instruction into IR1; 0 = inject NOP_INSN
ALUPC1  in  ADDR_W  PC increment applied on sequential update (0 freezes PC)
PCSel  in  1  1 = PC <= PC+ALUPC1; 0 = PC <= BranchTarget
BranchTarget  in  ADDR_W  redirect address
mem_rd  out  1  instruction read request
mem_addr  out  ADDR_W  request address, stable while mem_rd=1
mem_data  in  DATA_W  instruction, valid when mem_ready=1
mem_ready  in  1  completes the current request (single-cycle pulse)
IR1  out  DATA_W  instruction register to decode
PC1  out  ADDR_W  address of the instruction held in IR1
PC  out  ADDR_W  current fetch PC
fetch_stall  out  1  high in any cycle IR1 receives NOP because memory was not ready
fetch_err  out  1  sticky wait-timeout flag

Behaviour:
- Reset (reset=0, async): state S_INIT; PC=0, IR1=NOP_INSN, PC1=0, mem_rd=0, mem_addr=0, fetch_stall=0, fetch_err=0, wait counter=0.
- S_INIT: one cycle after reset deasserts; mem_rd=0; IR1 stays NOP. Next state S_REQ.
- S_REQ: mem_rd=1, mem_addr=PC (combinational, zero-wait capable).
  - mem_ready=1 (accept edge): IR1 <= IR1Sel ? mem_data : NOP_INSN; PC1 <= PC when IR1Sel=1, else hold. PC <= PCSel ? PC+ALUPC1 : BranchTarget. wait counter <= 0; fetch_stall=0. Stay in S_REQ.
  - mem_ready=0, PCSel=1: IR1 <= NOP_INSN; PC holds (ALUPC1 ignored); fetch_stall=1; counter++.
  - mem_ready=0, PCSel=0: IR1 <= NOP_INSN; fetch_stall=1; drop_addr <= PC; PC <= BranchTarget; go S_DROP.
- S_DROP: mem_rd=1, mem_addr=drop_addr (request must not change mid-flight). IR1 <= NOP_INSN each cycle, fetch_stall=1. Control inputs are ignored. On mem_ready, mem_data is discarded and the next state is S_REQ (new PC issued next cycle). Counter runs as in S_REQ.
- Wait counter: saturates at WAIT_LIMIT. When it reaches WAIT_LIMIT, fetch_err <= 1 (sticky until reset). Fetching continues.
- Arithmetic: PC+ALUPC1 is modulo 2^ADDR_W (8'hFF+1 = 8'h00). No carry out.
- mem_ready while mem_rd=0 (S_INIT) is ignored.
- Reset mid-request: immediate return to reset values. The in-flight response is not tracked.
- IR1, PC1, PC, fetch_err are registered. mem_rd and mem_addr are decoded from state and registers only, with no input-to-output combinational path.

Test Plan:
- Zero-wait stream: mem_ready=1 constantly, IR1Sel=1, ALUPC1=1, PCSel=1, mem_data=addr+8'h10 -> mem_addr 0,1,2,…; IR1 = 10,11,12 one cycle after each address; PC1 tracks.
- Branch freeze/redirect: at PC=5, drive IR1Sel=0, ALUPC1=0 for 2 accepts, then PCSel=0, BranchTarget=8'h40 -> IR1=NOP_INSN for 3 cycles, PC holds 5 then becomes 8'h40; next mem_addr=8'h40.
- Wait states: mem_ready low 3 cycles at PC=3 -> mem_addr stays 3, fetch_stall=1 and IR1=NOP for 3 cycles, PC unchanged; on ready IR1=mem_data, PC=4.
- Redirect during wait: at PC=7 mem_ready low, PCSel=0, BranchTarget=8'h20 -> S_DROP, mem_addr holds 7 until ready, data dropped (IR1=NOP), then mem_addr=8'h20.
- Wrap and timeout: PC=8'hFF, ALUPC1=1 accept -> PC=8'h00. Hold mem_ready low 15 cycles -> fetch_err=1 and it remains 1 after later accepts.
- Async reset asserted mid-S_DROP -> all outputs at reset values without waiting for a clock edge, then S_INIT for one cycle with mem_rd=0, then fetch from address 0.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC register, IR1/PC1 load, NOP injection, memory request.
module fetch_unit #(
  parameter int                 ADDR_W     = 8,
  parameter int                 DATA_W     = 8,
  parameter logic [DATA_W-1:0]  NOP_INSN   = 8'h0A,
  parameter int                 WAIT_LIMIT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              IR1Sel,
  input  logic [ADDR_W-1:0] ALUPC1,
  input  logic              PCSel,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] IR1,
  output logic [ADDR_W-1:0] PC1,
  output logic [ADDR_W-1:0] PC,
  output logic              fetch_stall,
  output logic              fetch_err
);

  localparam int               CNT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  typedef enum logic [1:0] {S_INIT, S_REQ, S_DROP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc1_q, pc1_d;
  logic [ADDR_W-1:0] drop_q, drop_d;
  logic [DATA_W-1:0] ir1_q, ir1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              stall_q, stall_d;
  logic              err_q, err_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc1_d   = pc1_q;
    drop_d  = drop_q;
    ir1_d   = ir1_q;
    cnt_d   = cnt_q;
    stall_d = 1'b0;
    err_d   = err_q;
    cnt_inc = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      S_INIT: begin
        ir1_d   = NOP_INSN;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (mem_ready) begin
          ir1_d = IR1Sel ? mem_data : NOP_INSN;
          if (IR1Sel) pc1_d = pc_q;
          pc_d  = PCSel ? pc_q + ALUPC1 : BranchTarget;
          cnt_d = '0;
        end else begin
          ir1_d   = NOP_INSN;
          stall_d = 1'b1;
          cnt_d   = cnt_inc;
          // A redirect cannot retarget the outstanding request; park its address and drain it.
          if (!PCSel) begin
            drop_d  = pc_q;
            pc_d    = BranchTarget;
            state_d = S_DROP;
          end
        end
      end
      S_DROP: begin
        ir1_d   = NOP_INSN;
        stall_d = 1'b1;
        if (mem_ready) begin
          cnt_d   = '0;
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_INIT;
    endcase
    if (cnt_d == LIMIT) err_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_INIT;
      pc_q    <= '0;
      pc1_q   <= '0;
      drop_q  <= '0;
      ir1_q   <= NOP_INSN;
      cnt_q   <= '0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc1_q   <= pc1_d;
      drop_q  <= drop_d;
      ir1_q   <= ir1_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign mem_rd      = (state_q != S_INIT);
  assign mem_addr    = (state_q == S_DROP) ? drop_q : pc_q;
  assign IR1         = ir1_q;
  assign PC1         = pc1_q;
  assign PC          = pc_q;
  assign fetch_stall = stall_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - table-driven scoreboard bench for fetch_unit.
module tb_fetch_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       IR1Sel;
  logic [7:0] ALUPC1;
  logic       PCSel;
  logic [7:0] BranchTarget;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_ready;
  logic [7:0] IR1;
  logic [7:0] PC1;
  logic [7:0] PC;
  logic       fetch_stall;
  logic       fetch_err;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clock(clock), .reset(reset), .IR1Sel(IR1Sel), .ALUPC1(ALUPC1), .PCSel(PCSel),
    .BranchTarget(BranchTarget), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mem_ready), .IR1(IR1), .PC1(PC1), .PC(PC), .fetch_stall(fetch_stall),
    .fetch_err(fetch_err)
  );

  always #5 clock = ~clock;

  // Instruction memory: word at address a is a+8'h10.
  assign mem_data = mem_addr + 8'h10;

  typedef struct {
    logic       sel;
    logic [7:0] inc;
    logic       pcsel;
    logic [7:0] bt;
    logic       rdy;
    logic       e_rd;
    logic [7:0] e_addr;
    logic [7:0] e_ir1;
    logic [7:0] e_pc1;
    logic [7:0] e_pc;
    logic       e_stall;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];
  vec_t expq[$];

  function automatic void add(input logic sel, input logic [7:0] inc, input logic pcsel,
                              input logic [7:0] bt, input logic rdy, input logic e_rd,
                              input logic [7:0] e_addr, input logic [7:0] e_ir1,
                              input logic [7:0] e_pc1, input logic [7:0] e_pc,
                              input logic e_stall, input logic e_err);
    vec_t v;
    v.sel = sel; v.inc = inc; v.pcsel = pcsel; v.bt = bt; v.rdy = rdy;
    v.e_rd = e_rd; v.e_addr = e_addr; v.e_ir1 = e_ir1; v.e_pc1 = e_pc1;
    v.e_pc = e_pc; v.e_stall = e_stall; v.e_err = e_err;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_reset_values(input int idx);
    check("rst_mem_rd", idx, 32'(mem_rd), 32'h0);
    check("rst_mem_addr", idx, 32'(mem_addr), 32'h0);
    check("rst_IR1", idx, 32'(IR1), 32'h0A);
    check("rst_PC1", idx, 32'(PC1), 32'h0);
    check("rst_PC", idx, 32'(PC), 32'h0);
    check("rst_stall", idx, 32'(fetch_stall), 32'h0);
    check("rst_err", idx, 32'(fetch_err), 32'h0);
  endtask

  // Entered and left at a falling edge.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    IR1Sel = v.sel; ALUPC1 = v.inc; PCSel = v.pcsel; BranchTarget = v.bt; mem_ready = v.rdy;
    #1;
    check("mem_rd", idx, 32'(mem_rd), 32'(v.e_rd));
    check("mem_addr", idx, 32'(mem_addr), 32'(v.e_addr));
    expq.push_back(v);
    @(posedge clock);
    #1;
    if (expq.size() == 0) begin
      check("sb_empty", idx, 32'h0, 32'h1);
    end else begin
      e = expq.pop_front();
      check("IR1", idx, 32'(IR1), 32'(e.e_ir1));
      check("PC1", idx, 32'(PC1), 32'(e.e_pc1));
      check("PC", idx, 32'(PC), 32'(e.e_pc));
      check("fetch_stall", idx, 32'(fetch_stall), 32'(e.e_stall));
      check("fetch_err", idx, 32'(fetch_err), 32'(e.e_err));
    end
    @(negedge clock);
  endtask

  initial begin
    //  sel inc   pcs bt     rdy rd addr   ir1    pc1    pc     stl err
    add(1, 8'h01, 1, 8'h00, 1, 0, 8'h00, 8'h0A, 8'h00, 8'h00, 0, 0);  // S_INIT ignores ready
    add(1, 8'h01, 1, 8'h00, 1, 1, 8'h00, 8'h10, 8'h00, 8'h01, 0, 0);
    add(1, 8'h01, 1, 8'h00, 1, 1, 8'h01, 8'h11, 8'h01, 8'h02, 0, 0);
    add(1, 8'h01, 1, 8'h00, 1, 1, 8'h02, 8'h12, 8'h02, 8'h03, 0, 0);
    for (int i = 0; i < 3; i++)
      add(1, 8'h01, 1, 8'h00, 0, 1, 8'h03, 8'h0A, 8'h02, 8'h03, 1, 0);
    add(1, 8'h01, 1, 8'h00, 1, 1, 8'h03, 8'h13, 8'h03, 8'h04, 0, 0);
    add(1, 8'h01, 1, 8'h00, 1, 1, 8'h04, 8'h14, 8'h04, 8'h05, 0, 0);
    add(0, 8'h00, 1, 8'h00, 1, 1, 8'h05, 8'h0A, 8'h04, 8'h05, 0, 0);  // freeze
    add(0, 8'h00, 1, 8'h00, 1, 1, 8'h05, 8'h0A, 8'h04, 8'h05, 0, 0);
    add(0, 8'h00, 0, 8'h40, 1, 1, 8'h05, 8'h0A, 8'h04, 8'h40, 0, 0);  // redirect
    add(1, 8'h01, 1, 8'h00, 1, 1, 8'h40, 8'h50, 8'h40, 8'h41, 0, 0);
    add(1, 8'h01, 0, 8'h07, 1, 1, 8'h41, 8'h51, 8'h41, 8'h07, 0, 0);
    add(1, 8'h01, 0, 8'h20, 0, 1, 8'h07, 8'h0A, 8'h41, 8'h20, 1, 0);  // redirect during wait
    add(1, 8'h05, 1, 8'h99, 0, 1, 8'h07, 8'h0A, 8'h41, 8'h20, 1, 0);  // S_DROP ignores controls
    add(1, 8'h05, 1, 8'h99, 1, 1, 8'h07, 8'h0A, 8'h41, 8'h20, 1, 0);  // dropped data
    add(1, 8'h01, 1, 8'h00, 1, 1, 8'h20, 8'h30, 8'h20, 8'h21, 0, 0);
    add(1, 8'h01, 0, 8'hFF, 1, 1, 8'h21, 8'h31, 8'h21, 8'hFF, 0, 0);
    add(1, 8'h01, 1, 8'h00, 1, 1, 8'hFF, 8'h0F, 8'hFF, 8'h00, 0, 0);  // wrap
    for (int i = 1; i <= 16; i++)
      add(1, 8'h01, 1, 8'h00, 0, 1, 8'h00, 8'h0A, 8'hFF, 8'h00, 1, (i >= 15) ? 1'b1 : 1'b0);
    add(1, 8'h01, 1, 8'h00, 1, 1, 8'h00, 8'h10, 8'h00, 8'h01, 0, 1);  // err sticky
    add(1, 8'h01, 1, 8'h00, 1, 1, 8'h01, 8'h11, 8'h01, 8'h02, 0, 1);
    add(1, 8'h01, 0, 8'h80, 0, 1, 8'h02, 8'h0A, 8'h01, 8'h80, 1, 1);  // enter S_DROP

    reset = 1'b0; IR1Sel = 1'b0; ALUPC1 = 8'h00; PCSel = 1'b1; BranchTarget = 8'h00;
    mem_ready = 1'b0;
    #12;
    check_reset_values(0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Async reset in the middle of S_DROP, away from any clock edge.
    #1;
    check("drop_mem_rd", 0, 32'(mem_rd), 32'h1);
    check("drop_mem_addr", 0, 32'(mem_addr), 32'h02);
    #1;
    reset = 1'b0;
    #1;
    check_reset_values(1);
    @(negedge clock);
    reset = 1'b1; mem_ready = 1'b1; IR1Sel = 1'b1; ALUPC1 = 8'h01; PCSel = 1'b1;
    #1;
    check("init_mem_rd", 0, 32'(mem_rd), 32'h0);
    @(posedge clock);
    #1;
    check("init_IR1", 0, 32'(IR1), 32'h0A);
    check("init_PC", 0, 32'(PC), 32'h00);
    check("req_mem_rd", 0, 32'(mem_rd), 32'h1);
    check("req_mem_addr", 0, 32'(mem_addr), 32'h00);
    @(posedge clock);
    #1;
    check("post_IR1", 0, 32'(IR1), 32'h10);
    check("post_PC1", 0, 32'(PC1), 32'h00);
    check("post_PC", 0, 32'(PC), 32'h01);
    check("post_err", 0, 32'(fetch_err), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
